// File: rtl/adbg_or1k_pkg.sv
// Shared definitions for the OR1K debug command sequencer: opcodes, STATUS layout
// and sequencer state encoding.
package adbg_or1k_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int REGSEL_WIDTH = 3;
  localparam int STATUS_WIDTH = 2;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP      = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_BWRITE32 = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_BREAD32  = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_IREG_WR  = 4'h9;
  localparam logic [OPCODE_WIDTH-1:0] OP_IREG_SEL = 4'hD;

  localparam logic [REGSEL_WIDTH-1:0] IREG_STATUS = 3'd0;

  localparam int STATUS_STALL_BIT = 0;
  localparam int STATUS_RST_BIT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    WFETCH,
    ACCESS,
    RDRET,
    DONE
  } or1k_seq_state_t;

  // Reserved opcodes and internal-register writes to anything but STATUS report an error.
  function automatic logic op_is_error(input logic [OPCODE_WIDTH-1:0] op,
                                       input logic [REGSEL_WIDTH-1:0] sel);
    case (op)
      OP_NOP, OP_BWRITE32, OP_BREAD32, OP_IREG_SEL: return 1'b0;
      OP_IREG_WR:                                   return sel != IREG_STATUS;
      default:                                      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/adbg_or1k_cmd_sequencer_if.sv
// Command, data-stream and CPU debug-port signals of the sequencer, bundled with
// modports for the sequencer (slave) and the JTAG/CPU environment (master).
interface adbg_or1k_cmd_sequencer_if
  import adbg_or1k_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [OPCODE_WIDTH-1:0] cmd_opcode_i;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [CNT_WIDTH-1:0]    cmd_count_i;
  logic [REGSEL_WIDTH-1:0] cmd_regsel_i;
  logic [STATUS_WIDTH-1:0] cmd_regdat_i;

  logic                    wdat_valid_i;
  logic                    wdat_ready_o;
  logic [DATA_WIDTH-1:0]   wdat_i;
  logic                    rdat_valid_o;
  logic                    rdat_ready_i;
  logic [DATA_WIDTH-1:0]   rdat_o;

  logic                    cpu_stb_o;
  logic                    cpu_we_o;
  logic [ADDR_WIDTH-1:0]   cpu_addr_o;
  logic [DATA_WIDTH-1:0]   cpu_data_o;
  logic [DATA_WIDTH-1:0]   cpu_data_i;
  logic                    cpu_ack_i;
  logic                    cpu_bp_i;
  logic                    cpu_stall_o;
  logic                    cpu_rst_o;

  logic [STATUS_WIDTH-1:0] status_o;
  logic [REGSEL_WIDTH-1:0] regsel_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_addr_i, cmd_count_i, cmd_regsel_i, cmd_regdat_i,
    input  wdat_valid_i, wdat_i, rdat_ready_i, cpu_data_i, cpu_ack_i, cpu_bp_i,
    output cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
    output cpu_stb_o, cpu_we_o, cpu_addr_o, cpu_data_o, cpu_stall_o, cpu_rst_o,
    output status_o, regsel_o, busy_o, done_o, err_o
  );

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_addr_i, cmd_count_i, cmd_regsel_i, cmd_regdat_i,
    output wdat_valid_i, wdat_i, rdat_ready_i, cpu_data_i, cpu_ack_i, cpu_bp_i,
    input  cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
    input  cpu_stb_o, cpu_we_o, cpu_addr_o, cpu_data_o, cpu_stall_o, cpu_rst_o,
    input  status_o, regsel_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/adbg_or1k_status.sv
// STATUS register (bit0 stall, bit1 reset) driving the CPU stall/reset lines.
// A breakpoint always sets the stall bit, overriding a same-cycle host write.
module adbg_or1k_status
  import adbg_or1k_pkg::*;
(
  input  logic                    cpu_clk_i,
  input  logic                    cpu_rstn_i,
  input  logic                    wr_en_i,
  input  logic [STATUS_WIDTH-1:0] wr_data_i,
  input  logic                    bp_i,
  output logic [STATUS_WIDTH-1:0] status_o,
  output logic                    stall_o,
  output logic                    rst_o
);
  logic [STATUS_WIDTH-1:0] status_d, status_q;

  always_comb begin
    status_d = status_q;
    if (wr_en_i) status_d = wr_data_i;
    if (bp_i)    status_d[STATUS_STALL_BIT] = 1'b1;
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) status_q <= '0;
    else             status_q <= status_d;
  end

  assign status_o = status_q;
  assign stall_o  = status_q[STATUS_STALL_BIT];
  assign rst_o    = status_q[STATUS_RST_BIT];

endmodule

// File: rtl/adbg_or1k_cmd_sequencer.sv
// CPU-side OR1K debug command sequencer: accepts one command, runs 32-bit bursts
// on the CPU debug port and streams words to/from the JTAG side.
module adbg_or1k_cmd_sequencer
  import adbg_or1k_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_INC   = 4
) (
  input logic                      cpu_clk_i,
  input logic                      cpu_rstn_i,
  adbg_or1k_cmd_sequencer_if.slave bus
);
  or1k_seq_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    remain_q, remain_d;
  logic                    is_read_q, is_read_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [REGSEL_WIDTH-1:0] regsel_q, regsel_d;

  logic                    cmd_accept;
  logic                    status_wr_en;
  logic [STATUS_WIDTH-1:0] status;
  logic                    stall;
  logic                    cpu_rst;

  assign cmd_accept   = (state_q == IDLE) && bus.cmd_valid_i;
  assign status_wr_en = cmd_accept && (bus.cmd_opcode_i == OP_IREG_WR)
                        && (bus.cmd_regsel_i == IREG_STATUS);

  // NOTE: every variable takes its registered value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    regsel_d  = regsel_q;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d    = bus.cmd_addr_i;
          remain_d  = bus.cmd_count_i;
          is_read_d = (bus.cmd_opcode_i == OP_BREAD32);
          err_d     = op_is_error(bus.cmd_opcode_i, bus.cmd_regsel_i);
          state_d   = DONE;
          case (bus.cmd_opcode_i)
            OP_BWRITE32: if (bus.cmd_count_i != '0) state_d = WFETCH;
            OP_BREAD32:  if (bus.cmd_count_i != '0) state_d = ACCESS;
            OP_IREG_WR, OP_IREG_SEL: regsel_d = bus.cmd_regsel_i;
            default: ;
          endcase
        end
      end

      WFETCH: begin
        if (bus.wdat_valid_i) begin
          wdata_d = bus.wdat_i;
          state_d = ACCESS;
        end
      end

      // The strobe is never retracted; address, direction and data hold until ack.
      ACCESS: begin
        if (bus.cpu_ack_i) begin
          addr_d   = addr_q + ADDR_WIDTH'(ADDR_INC);
          remain_d = remain_q - CNT_WIDTH'(1);
          if (is_read_q) begin
            rdata_d = bus.cpu_data_i;
            state_d = RDRET;
          end else begin
            state_d = (remain_q == CNT_WIDTH'(1)) ? DONE : WFETCH;
          end
        end
      end

      RDRET: begin
        if (bus.rdat_ready_i) state_d = (remain_q == '0) ? DONE : ACCESS;
      end

      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      regsel_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      regsel_q  <= regsel_d;
    end
  end

  adbg_or1k_status u_status (
    .cpu_clk_i  (cpu_clk_i),
    .cpu_rstn_i (cpu_rstn_i),
    .wr_en_i    (status_wr_en),
    .wr_data_i  (bus.cmd_regdat_i),
    .bp_i       (bus.cpu_bp_i),
    .status_o   (status),
    .stall_o    (stall),
    .rst_o      (cpu_rst)
  );

  assign bus.cmd_ready_o  = (state_q == IDLE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.err_o        = (state_q == DONE) && err_q;
  assign bus.wdat_ready_o = (state_q == WFETCH);
  assign bus.rdat_valid_o = (state_q == RDRET);
  assign bus.rdat_o       = rdata_q;
  assign bus.cpu_stb_o    = (state_q == ACCESS);
  assign bus.cpu_we_o     = (state_q == ACCESS) && !is_read_q;
  assign bus.cpu_addr_o   = addr_q;
  assign bus.cpu_data_o   = wdata_q;
  assign bus.status_o     = status;
  assign bus.cpu_stall_o  = stall;
  assign bus.cpu_rst_o    = cpu_rst;
  assign bus.regsel_o     = regsel_q;

endmodule

// File: tb/tb_adbg_or1k_cmd_sequencer.sv
// Self-checking bench for adbg_or1k_cmd_sequencer: directed scenarios plus random
// commands, checked every cycle against a transaction-level expectation model.
module tb_adbg_or1k_cmd_sequencer;
  import adbg_or1k_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adbg_or1k_cmd_sequencer_if bus ();

  adbg_or1k_cmd_sequencer dut (
    .cpu_clk_i  (clk),
    .cpu_rstn_i (rst_n),
    .bus        (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } acc_t;

  int n_checks = 0;
  int n_errors = 0;

  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  bit          exp_err[$];
  logic [31:0] wq[$];
  logic [31:0] obs_addr[$];
  logic [31:0] fixed_words[$];

  logic [1:0]  m_status;
  logic [2:0]  m_regsel;
  bit          m_busy, m_quick;
  int          done_cnt = 0;
  int          stb_cnt = 0;
  bit          last_err;
  logic [31:0] mem_seed;

  bit ack_hold = 0, rd_hold = 0, bp_rand = 0, bp_force = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC35A, a[31:16]} ^ mem_seed;
  endfunction

  function automatic bit exp_err_of(input logic [3:0] op, input logic [2:0] sel);
    if (op == 4'h9) return sel != 3'd0;
    return !(op inside {4'h0, 4'h3, 4'h7, 4'hD});
  endfunction

  // CPU debug port: acks each access after 0..5 wait cycles and returns memory words.
  initial begin
    int  ack_left;
    bit  armed;
    armed = 0;
    ack_left = 0;
    bus.cpu_ack_i  = 1'b0;
    bus.cpu_data_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.cpu_ack_i = 1'b0;
      if (bus.cpu_stb_o && !ack_hold) begin
        if (!armed) begin
          armed = 1;
          ack_left = $urandom_range(0, 5);
        end
        if (ack_left == 0) begin
          bus.cpu_ack_i  = 1'b1;
          bus.cpu_data_i = mem_word(bus.cpu_addr_o);
          armed = 0;
        end else begin
          ack_left--;
        end
      end else if (!bus.cpu_stb_o) begin
        armed = 0;
      end
      if (!bus.cpu_ack_i) bus.cpu_data_i = $urandom;
    end
  end

  // Write-data source: presents queued words with random idle gaps.
  initial begin
    bit hs;
    bus.wdat_valid_i = 1'b0;
    bus.wdat_i = '0;
    forever begin
      @(negedge clk);
      hs = bus.wdat_valid_i && bus.wdat_ready_o;
      @(posedge clk); #1;
      if (hs) void'(wq.pop_front());
      if (wq.size() == 0) bus.wdat_valid_i = 1'b0;
      else if (hs || !bus.wdat_valid_i) begin
        bus.wdat_valid_i = ($urandom_range(0, 3) != 0);
        bus.wdat_i = wq[0];
      end
    end
  end

  // Read-data sink with random backpressure, or held off entirely.
  initial begin
    bus.rdat_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rdat_ready_i = rd_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    bus.cpu_bp_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.cpu_bp_i = bp_rand ? ($urandom_range(0, 15) == 0) : bp_force;
    end
  end

  // Compare process: checks outputs against the model each cycle, then advances the model.
  initial begin
    acc_t        a;
    logic [31:0] r;
    bit          e, acc;
    bit          p_stb, p_ack, p_we, p_rv, p_rr;
    logic [31:0] p_addr, p_data, p_rdat;
    p_stb = 0; p_ack = 0; p_we = 0; p_rv = 0; p_rr = 0;
    p_addr = '0; p_data = '0; p_rdat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_stb", bus.cpu_stb_o, 0);
        check("rst_ready", bus.cmd_ready_o, 1);
        check("rst_status", bus.status_o, 0);
        check("rst_busy", bus.busy_o, 0);
        m_status = '0; m_regsel = '0; m_busy = 0; m_quick = 0;
        exp_acc.delete(); exp_rd.delete(); exp_err.delete();
        p_stb = 0; p_ack = 0; p_rv = 0; p_rr = 0;
      end else begin
        check("status", bus.status_o, m_status);
        check("stall", bus.cpu_stall_o, m_status[0]);
        check("cpu_rst", bus.cpu_rst_o, m_status[1]);
        check("regsel", bus.regsel_o, m_regsel);
        check("busy", bus.busy_o, m_busy);
        check("cmd_ready", bus.cmd_ready_o, !m_busy);
        if (m_quick) check("quick_done", bus.done_o, 1);
        if (bus.err_o) check("err_with_done", bus.done_o, 1);
        if (bus.done_o) begin
          done_cnt++;
          check("done_expected", exp_err.size() != 0, 1);
          if (exp_err.size() != 0) begin
            e = exp_err.pop_front();
            check("err_o", bus.err_o, e);
          end
          last_err = bus.err_o;
          check("acc_left_at_done", exp_acc.size(), 0);
          check("rd_left_at_done", exp_rd.size(), 0);
        end
        if (bus.cpu_stb_o) begin
          if (p_stb && !p_ack) begin
            check("stb_addr_stable", bus.cpu_addr_o, p_addr);
            check("stb_we_stable", bus.cpu_we_o, p_we);
            check("stb_data_stable", bus.cpu_data_o, p_data);
          end
          if (p_ack) check("gap_after_ack", bus.cpu_stb_o, 0);
          check("stb_vs_rvalid", bus.rdat_valid_o, 0);
          check("stb_vs_wready", bus.wdat_ready_o, 0);
          if (bus.cpu_ack_i) begin
            stb_cnt++;
            obs_addr.push_back(bus.cpu_addr_o);
            check("acc_expected", exp_acc.size() != 0, 1);
            if (exp_acc.size() != 0) begin
              a = exp_acc.pop_front();
              check("acc_addr", bus.cpu_addr_o, a.addr);
              check("acc_we", bus.cpu_we_o, a.we);
              if (a.we) check("acc_wdata", bus.cpu_data_o, a.data);
            end
          end
        end
        if (p_rv && !p_rr) begin
          check("rvalid_held", bus.rdat_valid_o, 1);
          check("rdat_stable", bus.rdat_o, p_rdat);
        end
        if (bus.rdat_valid_o && bus.rdat_ready_i) begin
          check("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) begin
            r = exp_rd.pop_front();
            check("rdat", bus.rdat_o, r);
          end
        end
        // Advance the model with the inputs the next edge will sample.
        m_quick = 0;
        if (bus.done_o) m_busy = 0;
        acc = bus.cmd_valid_i && !m_busy;
        if (acc) begin
          m_busy = 1;
          if (bus.cmd_opcode_i inside {4'h9, 4'hD}) m_regsel = bus.cmd_regsel_i;
          if (bus.cmd_opcode_i == 4'h9 && bus.cmd_regsel_i == 3'd0) m_status = bus.cmd_regdat_i;
          m_quick = !(bus.cmd_opcode_i inside {4'h3, 4'h7}) || (bus.cmd_count_i == 16'd0);
        end
        if (bus.cpu_bp_i) m_status[0] = 1'b1;
        p_stb = bus.cpu_stb_o; p_ack = bus.cpu_ack_i; p_we = bus.cpu_we_o;
        p_addr = bus.cpu_addr_o; p_data = bus.cpu_data_o;
        p_rv = bus.rdat_valid_o; p_rr = bus.rdat_ready_i; p_rdat = bus.rdat_o;
      end
    end
  end

  task automatic expect_cmd(input logic [3:0] op, input logic [31:0] addr,
                            input logic [15:0] cnt, input logic [2:0] sel);
    logic [31:0] a, w;
    exp_err.push_back(exp_err_of(op, sel));
    if (op == 4'h3 || op == 4'h7) begin
      for (int i = 0; i < int'(cnt); i++) begin
        a = addr + 32'(4 * i);
        if (op == 4'h3) begin
          w = (i < fixed_words.size()) ? fixed_words[i] : $urandom;
          wq.push_back(w);
          exp_acc.push_back('{addr: a, we: 1'b1, data: w});
        end else begin
          exp_acc.push_back('{addr: a, we: 1'b0, data: 32'h0});
          exp_rd.push_back(mem_word(a));
        end
      end
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [31:0] addr, input logic [15:0] cnt,
                          input logic [2:0] sel, input logic [1:0] dat);
    bit ok = 0;
    @(posedge clk); #1;
    bus.cmd_opcode_i = op; bus.cmd_addr_i = addr; bus.cmd_count_i = cnt;
    bus.cmd_regsel_i = sel; bus.cmd_regdat_i = dat; bus.cmd_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("cmd_accept");
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_opcode_i = 4'($urandom); bus.cmd_addr_i = $urandom; bus.cmd_count_i = 16'($urandom);
    bus.cmd_regsel_i = 3'($urandom); bus.cmd_regdat_i = 2'($urandom);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("done_wait");
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] addr, input logic [15:0] cnt,
                         input logic [2:0] sel, input logic [1:0] dat);
    expect_cmd(op, addr, cnt, sel);
    send_cmd(op, addr, cnt, sel, dat);
    wait_done();
    check("wq_drained", wq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int d0, s0;
    bit ok;
    logic [3:0] op;
    logic [31:0] addr;
    mem_seed = $urandom;
    bus.cmd_valid_i = 1'b0; bus.cmd_opcode_i = '0; bus.cmd_addr_i = '0;
    bus.cmd_count_i = '0; bus.cmd_regsel_i = '0; bus.cmd_regdat_i = '0;

    // Reset release
    do_reset();
    @(negedge clk);
    check("reset_cmd_ready", bus.cmd_ready_o, 1);
    check("reset_busy", bus.busy_o, 0);
    check("reset_done", bus.done_o, 0);
    check("reset_err", bus.err_o, 0);
    check("reset_stb", bus.cpu_stb_o, 0);
    check("reset_we", bus.cpu_we_o, 0);
    check("reset_addr", bus.cpu_addr_o, 0);
    check("reset_wready", bus.wdat_ready_o, 0);
    check("reset_rvalid", bus.rdat_valid_o, 0);
    check("reset_status", bus.status_o, 0);
    check("reset_regsel", bus.regsel_o, 0);

    // BWRITE32 0x1000 x3 with words A,B,C
    fixed_words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    obs_addr.delete();
    d0 = done_cnt;
    run_cmd(4'h3, 32'h0000_1000, 16'd3, 3'd0, 2'd0);
    fixed_words.delete();
    check("bw_count", obs_addr.size(), 3);
    if (obs_addr.size() == 3) begin
      check("bw_addr0", obs_addr[0], 32'h0000_1000);
      check("bw_addr1", obs_addr[1], 32'h0000_1004);
      check("bw_addr2", obs_addr[2], 32'h0000_1008);
    end
    check("bw_one_done", done_cnt - d0, 1);
    check("bw_err", last_err, 0);

    // BREAD32 across the address wrap, with the read stream held off
    obs_addr.delete();
    rd_hold = 1;
    expect_cmd(4'h7, 32'hFFFF_FFFC, 16'd2, 3'd0);
    send_cmd(4'h7, 32'hFFFF_FFFC, 16'd2, 3'd0, 2'd0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rdat_valid_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("br_rvalid");
    repeat (4) begin
      @(negedge clk);
      check("br_hold_rvalid", bus.rdat_valid_o, 1);
      check("br_hold_no_stb", bus.cpu_stb_o, 0);
      check("br_hold_rdat", bus.rdat_o, mem_word(32'hFFFF_FFFC));
    end
    rd_hold = 0;
    wait_done();
    check("br_count", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      check("br_addr0", obs_addr[0], 32'hFFFF_FFFC);
      check("br_addr1", obs_addr[1], 32'h0000_0000);
    end

    // STATUS writes and breakpoint priority
    run_cmd(4'h9, 32'h0, 16'd0, 3'd0, 2'b01);
    check("stall_set", bus.cpu_stall_o, 1);
    check("status_01", bus.status_o, 2'b01);
    expect_cmd(4'h9, 32'h0, 16'd0, 3'd0);
    bp_force = 1;
    send_cmd(4'h9, 32'h0, 16'd0, 3'd0, 2'b00);
    bp_force = 0;
    wait_done();
    check("bp_wins_stall", bus.cpu_stall_o, 1);
    run_cmd(4'h9, 32'h0, 16'd0, 3'd0, 2'b00);
    check("stall_cleared", bus.cpu_stall_o, 0);

    // Writes to a non-STATUS index, reserved opcode, empty burst
    run_cmd(4'h9, 32'h0, 16'd0, 3'd3, 2'b10);
    check("ireg3_regsel", bus.regsel_o, 3);
    check("ireg3_status", bus.status_o, 0);
    check("ireg3_err", last_err, 1);
    run_cmd(4'h5, 32'h0, 16'd4, 3'd0, 2'b11);
    check("op5_err", last_err, 1);
    check("op5_status", bus.status_o, 0);
    run_cmd(4'hD, 32'h0, 16'd0, 3'd5, 2'b11);
    check("sel_regsel", bus.regsel_o, 5);
    check("sel_err", last_err, 0);
    s0 = stb_cnt;
    d0 = done_cnt;
    run_cmd(4'h3, 32'h0000_2000, 16'd0, 3'd0, 2'd0);
    check("cnt0_no_stb", stb_cnt - s0, 0);
    check("cnt0_done", done_cnt - d0, 1);

    // Reset in the middle of a 4-word read
    run_cmd(4'h9, 32'h0, 16'd0, 3'd0, 2'b11);
    check("status_11", bus.status_o, 2'b11);
    ack_hold = 1;
    expect_cmd(4'h7, 32'h0000_0200, 16'd4, 3'd0);
    send_cmd(4'h7, 32'h0000_0200, 16'd4, 3'd0, 2'd0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cpu_stb_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("rst_stb_wait");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_stb", bus.cpu_stb_o, 0);
    check("async_stall", bus.cpu_stall_o, 0);
    check("async_rst", bus.cpu_rst_o, 0);
    check("async_busy", bus.busy_o, 0);
    repeat (2) @(posedge clk);
    ack_hold = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.cmd_ready_o, 1);
    obs_addr.delete();
    d0 = done_cnt;
    run_cmd(4'h3, 32'h0000_0300, 16'd2, 3'd0, 2'd0);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_count", obs_addr.size(), 2);
    if (obs_addr.size() == 2) check("post_rst_addr1", obs_addr[1], 32'h0000_0304);

    // Random commands with random breakpoints, ack delays and backpressure
    bp_rand = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 4'h3;
        3, 4, 5: op = 4'h7;
        6:       op = 4'h9;
        7:       op = 4'hD;
        8:       op = 4'h0;
        default: op = 4'($urandom);
      endcase
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      run_cmd(op, addr, 16'($urandom_range(0, 5)), 3'($urandom), 2'($urandom));
    end
    bp_rand = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
